mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter: OUT_DEPTH, 4, max outstanding accepted-but-unanswered requests (power of 2, >=2).
REQ-002 Parameter: STARVE_LIMIT, 4, consecutive data grants while inst waits before inst is forced a grant.
REQ-003 Port: clk  in  1  clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  reset, synchronous, active-high.
REQ-005 Port: inst_req, inst_wr  in  1 each; inst_size  in  2; inst_wstrb  in  4; inst_addr, inst_wdata  in  32 each: fetch-side SRAM-like request.
REQ-006 Port: inst_addr_ok, inst_data_ok  out  1 each; inst_rdata  out  32: fetch-side handshake and read data.
REQ-007 Port: data_req, data_wr  in  1 each; data_size  in  2; data_wstrb  in  4; data_addr, data_wdata  in  32 each: load/store-side request.
REQ-008 Port: data_addr_ok, data_data_ok  out  1 each; data_rdata  out  32: load/store-side handshake and read data.
REQ-009 Port: mem_req, mem_wr  out  1 each; mem_size  out  2; mem_wstrb  out  4; mem_addr, mem_wdata  out  32 each: shared memory port request.
REQ-010 Port: mem_addr_ok, mem_data_ok  in  1 each; mem_rdata  in  32: shared port handshake; responses return in acceptance order.
REQ-011 Port: err_resp  out  1  sticky flag: mem_data_ok received with no outstanding request.

Function
REQ-012 FSM states IDLE, GNT_D, GNT_I; mem_req SHALL equal (state != IDLE).
REQ-013 IDLE: if tracker not full and data_req, go GNT_D, unless inst_req and starve counter == STARVE_LIMIT, then GNT_I; else if inst_req and not full, go GNT_I; else stay.
REQ-014 Grant decision takes one cycle: a request first seen in IDLE appears on mem_req the following cycle (min latency 1).
REQ-015 In GNT_x, mem_* request fields SHALL be combinationally driven from the granted requester's current inputs; other requester's inputs ignored.
REQ-016 Grant held (no switching) until mem_addr_ok; on mem_req & mem_addr_ok, return to IDLE next cycle.
REQ-017 x_addr_ok = mem_addr_ok & (state == GNT_x); never asserted for the non-granted requester.
REQ-018 Requester deasserting req while granted and before addr_ok is a protocol violation; behaviour unspecified, no assertion required.
REQ-019 Tracker: FIFO of 1-bit IDs (0=inst, 1=data), OUT_DEPTH entries, count 0..OUT_DEPTH; push granted ID on mem_req & mem_addr_ok; pop on mem_data_ok when count > 0.
REQ-020 Simultaneous push and pop: count unchanged, both pointers advance; pointers wrap modulo OUT_DEPTH.
REQ-021 Full (count == OUT_DEPTH): no new grant from IDLE; a grant already in GNT_x still completes only after a pop frees a slot — mem_req deasserted while full-and-no-pop is forbidden, so grant SHALL NOT be issued when count == OUT_DEPTH-1 and state != IDLE would overflow; i.e. IDLE grants only if count + (push pending ? 1 : 0) < OUT_DEPTH.
REQ-022 Response routing: inst_data_ok = mem_data_ok & count>0 & head==0; data_data_ok = mem_data_ok & count>0 & head==1; inst_rdata = data_rdata = mem_rdata.
REQ-023 mem_data_ok with count == 0: no pop, no requester data_ok, err_resp set to 1 and held until reset.
REQ-024 Starve counter (width clog2(STARVE_LIMIT+1)): +1 on data acceptance while inst_req high, saturating; cleared on inst acceptance or whenever inst_req low in IDLE.
REQ-025 Data and inst addr handshakes may complete in the same cycle as an unrelated data_ok; both handled independently.

Reset
REQ-026 On reset: state IDLE, count 0, pointers 0, starve counter 0, err_resp 0; thus mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok all 0.
REQ-027 Reset mid-transaction discards all outstanding IDs; memory responses arriving after reset set err_resp per REQ-023.

Verification
REQ-028 Both reqs high in IDLE, mem_addr_ok=1 always -> cycle1 GNT_D, data_addr_ok=1, mem_addr=data_addr; inst granted next opportunity.
REQ-029 data_req and inst_req held high, mem_addr_ok=1 -> 4 data grants, then 1 inst grant, pattern repeats (STARVE_LIMIT=4).
REQ-030 mem_data_ok held 0, continuous requests -> exactly 4 acceptances, mem_req then stays 0; one mem_data_ok -> one new grant.
REQ-031 Accept inst (addr 0x1000) then data (addr 0x2000); responses rdata 0xAAAA then 0xBBBB -> inst_data_ok with 0xAAAA, then data_data_ok with 0xBBBB.
REQ-032 Push and pop in same cycle at count 3 -> count stays 3, pointer wrap correct across 10 iterations.
REQ-033 Reset asserted with 2 outstanding, then mem_data_ok -> no x_data_ok, err_resp=1 until next reset.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: arbitrates an instruction-fetch and a load/store SRAM-like
// requester onto one shared memory port.
//   clk, reset        : clock, synchronous active-high reset
//   inst_* / data_*   : requester request fields in, addr_ok/data_ok/rdata out
//   mem_*             : shared port request out, addr_ok/data_ok/rdata in
//   err_resp          : sticky, memory returned data with nothing outstanding
// Responses return in acceptance order; a FIFO of requester IDs routes them.
module mem_req_arbiter #(
  parameter int unsigned OUT_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        err_resp
);

  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(OUT_DEPTH);
  localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    GNT_D,
    GNT_I
  } state_t;

  state_t               state;
  logic [OUT_DEPTH-1:0] id_fifo;     // 0 = inst, 1 = data
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [ST_W-1:0]      starve_cnt;
  logic                 err_q;

  logic accept;
  logic tracked;
  logic pop;
  logic head_id;
  logic not_full;

  assign mem_req  = (state != IDLE);
  assign accept   = mem_req & mem_addr_ok;
  assign tracked  = (count != '0);
  assign pop      = mem_data_ok & tracked;
  assign head_id  = id_fifo[rd_ptr];
  // Only IDLE issues grants and no push is pending there, so the registered
  // count alone decides whether another acceptance fits in the tracker.
  assign not_full = (count < FULL_CNT);

  assign inst_addr_ok = mem_addr_ok & (state == GNT_I);
  assign data_addr_ok = mem_addr_ok & (state == GNT_D);
  assign inst_data_ok = pop & ~head_id;
  assign data_data_ok = pop &  head_id;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err_resp     = err_q;

  // Request fields follow the granted requester's live inputs.
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      GNT_D: begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end
      GNT_I: begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      id_fifo    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (not_full && data_req) begin
            state <= (inst_req && starve_cnt == STARVE_MAX) ? GNT_I : GNT_D;
          end else if (not_full && inst_req) begin
            state <= GNT_I;
          end
        end
        GNT_D, GNT_I: begin
          if (mem_addr_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        id_fifo[wr_ptr] <= (state == GNT_D);
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (accept && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!accept && pop) begin
        count <= count - CNT_W'(1);
      end

      if (state == GNT_I && mem_addr_ok) begin
        starve_cnt <= '0;
      end else if (state == IDLE && !inst_req) begin
        starve_cnt <= '0;
      end else if (state == GNT_D && mem_addr_ok && inst_req &&
                   starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + ST_W'(1);
      end

      if (mem_data_ok && !tracked) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed stimulus with queue-based scoreboard for
// mem_req_arbiter. Expected grants and responses are queued by the tests;
// monitors compare whenever the DUT signals addr_ok or data_ok.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err_resp;

  always #5 clk = ~clk;

  mem_req_arbiter #(.OUT_DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata),
    .err_resp(err_resp)
  );

  typedef struct packed {
    logic        inst_ok;
    logic        data_ok;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct packed {
    logic        inst_ok;
    logic        data_ok;
    logic [31:0] rdata;
  } rsp_t;

  localparam logic [31:0] KEY     = 32'hC0DE_0000;
  localparam logic        I_WR    = 1'b0;
  localparam logic [1:0]  I_SIZE  = 2'd2;
  localparam logic [3:0]  I_WSTRB = 4'b0000;
  localparam logic [31:0] I_WDATA = 32'h1111_1111;
  localparam logic        D_WR    = 1'b1;
  localparam logic [1:0]  D_SIZE  = 2'd1;
  localparam logic [3:0]  D_WSTRB = 4'b0011;
  localparam logic [31:0] D_WDATA = 32'h2222_3333;

  gnt_t        exp_gnt[$];
  rsp_t        exp_rsp[$];
  logic [31:0] pend[$];
  logic [31:0] rdata_ovr[$];

  int n_cmp   = 0;
  int n_err   = 0;
  int gnt_cnt = 0;
  bit resp_en = 1'b0;
  bit sync_en = 1'b0;
  int resp_once = 0;
  int stray_n   = 0;

  gnt_t g_act;
  rsp_t r_act;

  function automatic void check(string name, logic [79:0] act, logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_gnt(bit is_data, logic [31:0] addr);
    if (is_data) exp_gnt.push_back({1'b0, 1'b1, D_WR, D_SIZE, D_WSTRB, addr, D_WDATA});
    else         exp_gnt.push_back({1'b1, 1'b0, I_WR, I_SIZE, I_WSTRB, addr, I_WDATA});
  endfunction

  function automatic void push_rsp(bit is_data, logic [31:0] rdata);
    exp_rsp.push_back({~is_data, is_data, rdata});
  endfunction

  // Grant / response monitors.
  always @(negedge clk) begin
    if (!reset) begin
      if (inst_addr_ok || data_addr_ok) begin
        g_act = {inst_addr_ok, data_addr_ok, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};
        gnt_cnt++;
        if (exp_gnt.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL grant_unexpected: got %h, expected none", g_act);
        end else begin
          check("grant", 80'(g_act), 80'(exp_gnt.pop_front()));
        end
      end
      if (inst_data_ok || data_data_ok) begin
        r_act = {inst_data_ok, data_data_ok, inst_data_ok ? inst_rdata : data_rdata};
        if (exp_rsp.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got %h, expected none", r_act);
        end else begin
          check("response", 80'(r_act), 80'(exp_rsp.pop_front()));
        end
      end
    end
  end

  // Memory model: records accepted addresses in order, answers from them.
  always @(negedge clk) begin
    if (!reset && mem_req && mem_addr_ok) pend.push_back(mem_addr);
  end

  initial begin
    logic [31:0] a;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_data_ok = 1'b0;
      if (!reset) begin
        if (stray_n > 0) begin
          stray_n--;
          mem_data_ok = 1'b1;
          mem_rdata   = 32'hDEAD_BEEF;
        end else if (pend.size() > 0 &&
                     (resp_en || resp_once > 0 || (sync_en && mem_req && mem_addr_ok))) begin
          if (resp_once > 0) resp_once--;
          a = pend.pop_front();
          mem_data_ok = 1'b1;
          mem_rdata   = (rdata_ovr.size() > 0) ? rdata_ovr.pop_front() : (a ^ KEY);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    inst_req  = 1'b0;
    data_req  = 1'b0;
    resp_en   = 1'b0;
    sync_en   = 1'b0;
    resp_once = 0;
    stray_n   = 0;
    tick(2);
    pend.delete();
    exp_gnt.delete();
    exp_rsp.delete();
    rdata_ovr.delete();
    reset = 1'b0;
  endtask

  task automatic wait_gnt(int target, int budget);
    int g = 0;
    while (gnt_cnt < target && g < budget) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (gnt_cnt < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL gnt_timeout: got %0d, expected %0d", gnt_cnt, target);
    end
  endtask

  task automatic drain(string name);
    int g = 0;
    while ((exp_rsp.size() > 0 || exp_gnt.size() > 0) && g < 200) begin
      tick(1);
      g++;
    end
    check({name, "_rsp_left"}, 80'(exp_rsp.size()), 80'(0));
    check({name, "_gnt_left"}, 80'(exp_gnt.size()), 80'(0));
  endtask

  task automatic idle_checks(string name, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, 80'(mem_req), 80'(0));
    end
    tick(1);
  endtask

  initial begin
    int base;
    inst_wr = I_WR; inst_size = I_SIZE; inst_wstrb = I_WSTRB; inst_wdata = I_WDATA;
    data_wr = D_WR; data_size = D_SIZE; data_wstrb = D_WSTRB; data_wdata = D_WDATA;
    inst_addr = 32'h0000_1000;
    data_addr = 32'h0000_2000;
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    reset = 1'b1;
    tick(1);

    // Reset state and starvation pattern.
    do_reset();
    @(negedge clk);
    check("reset_outputs",
          80'({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_resp}),
          80'(6'b0));
    tick(1);
    mem_addr_ok = 1'b1;
    resp_en     = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        push_gnt(1'b1, 32'h0000_2000);
        push_rsp(1'b1, 32'h0000_2000 ^ KEY);
      end
      push_gnt(1'b0, 32'h0000_1000);
      push_rsp(1'b0, 32'h0000_1000 ^ KEY);
    end
    base = gnt_cnt;
    inst_req = 1'b1;
    data_req = 1'b1;
    @(negedge clk);
    check("latency_idle", 80'(mem_req), 80'(0));
    @(negedge clk);
    check("first_grant", 80'({mem_req, data_addr_ok, inst_addr_ok, mem_addr}),
          80'({1'b1, 1'b1, 1'b0, 32'h0000_2000}));
    wait_gnt(base + 10, 60);
    tick(1);
    inst_req = 1'b0;
    data_req = 1'b0;
    drain("starve");
    check("starve_err", 80'(err_resp), 80'(0));

    // Tracker full with no responses; one response frees one slot.
    do_reset();
    mem_addr_ok = 1'b1;
    for (int j = 0; j < 4; j++) begin
      push_gnt(1'b1, 32'h0000_2000);
      push_rsp(1'b1, 32'h0000_2000 ^ KEY);
    end
    push_gnt(1'b0, 32'h0000_1000);
    push_rsp(1'b0, 32'h0000_1000 ^ KEY);
    base = gnt_cnt;
    inst_req = 1'b1;
    data_req = 1'b1;
    wait_gnt(base + 4, 40);
    idle_checks("full_no_req", 8);
    check("full_count", 80'(gnt_cnt - base), 80'(4));
    resp_once = 1;
    wait_gnt(base + 5, 20);
    idle_checks("refull_no_req", 6);
    check("refull_count", 80'(gnt_cnt - base), 80'(5));
    inst_req = 1'b0;
    data_req = 1'b0;
    resp_en  = 1'b1;
    drain("full");

    // In-order routing with explicit read data.
    do_reset();
    mem_addr_ok = 1'b1;
    push_gnt(1'b0, 32'h0000_1000);
    push_gnt(1'b1, 32'h0000_2000);
    push_rsp(1'b0, 32'h0000_AAAA);
    push_rsp(1'b1, 32'h0000_BBBB);
    rdata_ovr.push_back(32'h0000_AAAA);
    rdata_ovr.push_back(32'h0000_BBBB);
    base = gnt_cnt;
    inst_req = 1'b1;
    wait_gnt(base + 1, 10);
    tick(1);
    inst_req = 1'b0;
    data_req = 1'b1;
    wait_gnt(base + 2, 10);
    tick(1);
    data_req = 1'b0;
    resp_en  = 1'b1;
    drain("route");

    // Simultaneous push/pop at count 3 across pointer wrap.
    do_reset();
    mem_addr_ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      push_gnt(1'b1, 32'h0000_3000 + 32'(16 * i));
      push_rsp(1'b1, (32'h0000_3000 + 32'(16 * i)) ^ KEY);
    end
    base = gnt_cnt;
    data_req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      data_addr = 32'h0000_3000 + 32'(16 * i);
      if (i == 3)  sync_en = 1'b1;
      if (i == 13) sync_en = 1'b0;
      wait_gnt(base + i + 1, 20);
      tick(1);
    end
    idle_checks("wrap_full_no_req", 6);
    check("wrap_count", 80'(gnt_cnt - base), 80'(14));
    data_req = 1'b0;
    resp_en  = 1'b1;
    drain("wrap");
    check("wrap_err", 80'(err_resp), 80'(0));

    // Reset with outstanding requests, then a stray response.
    do_reset();
    mem_addr_ok = 1'b1;
    data_addr   = 32'h0000_4000;
    push_gnt(1'b1, 32'h0000_4000);
    push_gnt(1'b1, 32'h0000_4000);
    base = gnt_cnt;
    data_req = 1'b1;
    wait_gnt(base + 2, 20);
    tick(1);
    data_req = 1'b0;
    tick(2);
    do_reset();
    @(negedge clk);
    check("err_after_reset", 80'(err_resp), 80'(0));
    tick(1);
    stray_n = 1;
    @(negedge clk);
    check("stray_cycle", 80'({mem_data_ok, inst_data_ok, data_data_ok, err_resp}),
          80'(4'b1000));
    @(negedge clk);
    check("err_set", 80'(err_resp), 80'(1));
    tick(5);
    @(negedge clk);
    check("err_sticky", 80'(err_resp), 80'(1));
    tick(1);
    do_reset();
    @(negedge clk);
    check("err_cleared", 80'(err_resp), 80'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
